// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: reset PC default, FSM encodings, flush NOP
// and the FIFO entry layout (instruction plus its PC).
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction ROM port, redirect input and the
// valid/ready instruction handoff to decode.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_fault,
        input  imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_fault,
        output imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Circular-buffer FIFO for fetched instructions; synchronous clear, exposes
// occupancy, and accepts push together with pop when full.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: PC, ROM requests, 2-deep buffer and redirect flush.
// Build option FETCH_MISALIGN_CHECK_EN: misaligned redirect targets raise fetch_fault.
//
// state    | meaning
// ST_RESET | held during reset and the first cycle after release; no requests
// ST_RUN   | fetching; request whenever buffer space will remain
// ST_FAULT | misaligned redirect seen; idle until an aligned redirect
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_e state;
    fetch_state_e state_next;
    fetch_entry_t resp;
    fetch_entry_t fifo_head;

    logic [31:0] pc;
    logic [31:0] inflight_pc;
    logic [31:0] idle_inst;
    logic [31:0] idle_pc;
    logic [31:0] target;
    logic        inflight;
    logic        misalign;
    logic        pop;
    logic        req;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occ;

    assign target = bus.redirect_pc & ~32'h3;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign        = |bus.redirect_pc[1:0];
    assign bus.fetch_fault = (state == ST_FAULT);
`else
    assign misalign        = 1'b0;
    assign bus.fetch_fault = 1'b0;
`endif

    // A response is shown to decode in the cycle it returns, so the
    // in-flight slot counts toward occupancy alongside the buffer.
    assign occ = (CW+1)'(fifo_count) + (CW+1)'(inflight) - (CW+1)'(pop);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RESET;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        req        = 1'b0;
        case (state)
            ST_RESET: state_next = (bus.redirect_valid && misalign) ? ST_FAULT : ST_RUN;
            ST_RUN: begin
                req = !bus.redirect_valid && (occ < (CW+1)'(BUF_DEPTH));
                if (bus.redirect_valid && misalign) state_next = ST_FAULT;
            end
            ST_FAULT: begin
                if (bus.redirect_valid && !misalign) state_next = ST_RUN;
            end
            default: state_next = ST_RESET;
        endcase
    end

    assign resp           = '{pc: inflight_pc, inst: bus.imem_rdata};
    assign bus.inst_valid = !fifo_empty || inflight;
    assign pop            = bus.inst_valid && bus.inst_ready;
    assign fifo_pop       = pop && !fifo_empty;
    assign fifo_push      = inflight && !bus.redirect_valid && !(pop && fifo_empty);
    assign bus.imem_req   = req;
    assign bus.imem_addr  = pc;

    always_comb begin
        bus.inst    = idle_inst;
        bus.inst_pc = idle_pc;
        if (!fifo_empty) begin
            bus.inst    = fifo_head.inst;
            bus.inst_pc = fifo_head.pc;
        end else if (inflight) begin
            bus.inst    = resp.inst;
            bus.inst_pc = resp.pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
            idle_inst   <= '0;
            idle_pc     <= RESET_PC;
        end else begin
            inflight <= req;
            if (req) inflight_pc <= pc;
            if (bus.redirect_valid) begin
                pc        <= target;
                idle_inst <= NOP_INST;
                idle_pc   <= target;
            end else if (req) begin
                pc <= next_pc(pc);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (bus.redirect_valid),
        .push      (fifo_push),
        .push_data (resp),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run checked against a stream-level model of the fetch stage.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          DEPTH  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] fetch_pc;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ROM image: ADDI/ORI/OR at 0x0..0x8, address-unique words elsewhere.
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h0300_E113;
            32'h8:   return 32'h0020_E1B3;
            default: return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= rom(bus.imem_addr);
        else              bus.imem_rdata <= $urandom;
    end

    task automatic tick(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        bus.inst_ready     = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.inst_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.inst_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
        checks++; if (bus.imem_addr !== RST_PC) begin errors++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr, RST_PC); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.inst_valid); end
        checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", bus.inst); end
        checks++; if (bus.inst_pc !== RST_PC) begin errors++; $display("FAIL reset_inst_pc got=%h exp=%h", bus.inst_pc, RST_PC); end
        checks++; if (bus.fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", bus.fetch_fault); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL release_cycle0_req got=%b exp=0", bus.imem_req); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL release_cycle0_valid got=%b exp=0", bus.inst_valid); end
    endtask

    // Continues from cycle 0 after reset release.
    task automatic test_startup();
        logic [31:0] p;
        for (int c = 1; c <= 6; c++) begin
            tick(1'b1, 1'b0, 32'h0);
            checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL startup_req c=%0d got=%b exp=1", c, bus.imem_req); end
            checks++; if (bus.imem_addr !== 32'(4 * (c - 1))) begin errors++; $display("FAIL startup_addr c=%0d got=%h exp=%h", c, bus.imem_addr, 32'(4 * (c - 1))); end
            if (c == 1) begin
                checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL startup_valid c=1 got=%b exp=0", bus.inst_valid); end
            end else begin
                p = 32'(4 * (c - 2));
                checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL startup_valid c=%0d got=%b exp=1", c, bus.inst_valid); end
                checks++; if (bus.inst_pc !== p) begin errors++; $display("FAIL startup_inst_pc c=%0d got=%h exp=%h", c, bus.inst_pc, p); end
                checks++; if (bus.inst !== rom(p)) begin errors++; $display("FAIL startup_inst c=%0d got=%h exp=%h", c, bus.inst, rom(p)); end
            end
        end
        exp_pc   = 32'd20;
        fetch_pc = 32'd24;
    endtask

    task automatic test_backpressure();
        for (int h = 0; h < 5; h++) begin
            tick(1'b0, 1'b0, 32'h0);
            checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc || bus.inst !== rom(exp_pc)) begin
                errors++; $display("FAIL hold_head h=%0d got v=%b pc=%h i=%h exp pc=%h i=%h", h, bus.inst_valid, bus.inst_pc, bus.inst, exp_pc, rom(exp_pc));
            end
            if (bus.imem_req === 1'b1) begin
                checks++; if (bus.imem_addr !== fetch_pc) begin errors++; $display("FAIL hold_addr got=%h exp=%h", bus.imem_addr, fetch_pc); end
                fetch_pc = fetch_pc + 32'd4;
            end
            checks++; if (fetch_pc - exp_pc > 32'(4 * DEPTH)) begin errors++; $display("FAIL hold_buffered got=%0d exp<=%0d", (fetch_pc - exp_pc) / 4, DEPTH); end
            if (h >= 2) begin
                checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL hold_req_full h=%0d got=%b exp=0", h, bus.imem_req); end
            end
        end
        for (int r = 0; r < 6; r++) begin
            tick(1'b1, 1'b0, 32'h0);
            if (r == 0) begin
                checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL resume_req got=%b exp=1", bus.imem_req); end
            end
            if (bus.imem_req === 1'b1) begin
                checks++; if (bus.imem_addr !== fetch_pc) begin errors++; $display("FAIL resume_addr got=%h exp=%h", bus.imem_addr, fetch_pc); end
                fetch_pc = fetch_pc + 32'd4;
            end
            checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc || bus.inst !== rom(exp_pc)) begin
                errors++; $display("FAIL resume_stream r=%0d got v=%b pc=%h i=%h exp pc=%h", r, bus.inst_valid, bus.inst_pc, bus.inst, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_redirect();
        logic [31:0] p;
        repeat (3) tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 32'h40);
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL redir_cycle_req got=%b exp=0", bus.imem_req); end
        tick(1'b1, 1'b0, 32'h0);
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL redir_n1_valid got=%b exp=0", bus.inst_valid); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin errors++; $display("FAIL redir_n1_req got=%b addr=%h exp=1 addr=00000040", bus.imem_req, bus.imem_addr); end
        checks++; if (bus.inst !== NOP) begin errors++; $display("FAIL redir_flush_inst got=%h exp=%h", bus.inst, NOP); end
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 1'b0, 32'h0);
            p = 32'h40 + 32'(4 * k);
            checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== p || bus.inst !== rom(p)) begin
                errors++; $display("FAIL redir_stream k=%0d got v=%b pc=%h i=%h exp pc=%h", k, bus.inst_valid, bus.inst_pc, bus.inst, p);
            end
        end
    endtask

    task automatic test_redirect_pop();
        int n8;
        n8 = 0;
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            tick(1'b1, (c == 4), 32'h100);
            if (bus.inst_valid === 1'b1 && bus.inst_pc === 32'h8) n8++;
            if (c == 4) begin
                checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h8) begin errors++; $display("FAIL redir_pop_head got v=%b pc=%h exp v=1 pc=00000008", bus.inst_valid, bus.inst_pc); end
            end
            if (c == 5) begin
                checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL redir_pop_gap got=%b exp=0", bus.inst_valid); end
            end
            if (c >= 6) begin
                checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100 + 32'(4 * (c - 6))) begin
                    errors++; $display("FAIL redir_pop_next c=%0d got v=%b pc=%h exp pc=%h", c, bus.inst_valid, bus.inst_pc, 32'h100 + 32'(4 * (c - 6)));
                end
            end
        end
        checks++; if (n8 != 1) begin errors++; $display("FAIL redir_pop_once got=%0d exp=1", n8); end
    endtask

    task automatic test_misalign();
        tick(1'b1, 1'b1, 32'h42);
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 1'b0, 32'h0);
            checks++; if (bus.fetch_fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
                errors++; $display("FAIL fault_hold k=%0d got fault=%b req=%b valid=%b exp 1,0,0", k, bus.fetch_fault, bus.imem_req, bus.inst_valid);
            end
        end
        tick(1'b1, 1'b1, 32'h44);
        tick(1'b1, 1'b0, 32'h0);
        checks++; if (bus.fetch_fault !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h44) begin
            errors++; $display("FAIL fault_clear got fault=%b req=%b addr=%h exp 0,1,00000044", bus.fetch_fault, bus.imem_req, bus.imem_addr);
        end
        tick(1'b1, 1'b0, 32'h0);
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h44 || bus.inst !== rom(32'h44)) begin
            errors++; $display("FAIL fault_resume got v=%b pc=%h exp pc=00000044", bus.inst_valid, bus.inst_pc);
        end
`else
        tick(1'b1, 1'b0, 32'h0);
        checks++; if (bus.fetch_fault !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
            errors++; $display("FAIL misalign_forced got fault=%b req=%b addr=%h exp 0,1,00000040", bus.fetch_fault, bus.imem_req, bus.imem_addr);
        end
        tick(1'b1, 1'b0, 32'h0);
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h40 || bus.inst !== rom(32'h40)) begin
            errors++; $display("FAIL misalign_fetch got v=%b pc=%h exp pc=00000040", bus.inst_valid, bus.inst_pc);
        end
`endif
    endtask

    task automatic test_reset_midstream();
        repeat (4) tick(1'b0, 1'b0, 32'h0);
        checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL midreset_prefill got=%b exp=1", bus.inst_valid); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== RST_PC || bus.inst_valid !== 1'b0 ||
                      bus.inst !== 32'h0 || bus.inst_pc !== RST_PC || bus.fetch_fault !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs got req=%b addr=%h v=%b i=%h pc=%h f=%b", bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst, bus.inst_pc, bus.fetch_fault);
        end
        tick(1'b1, 1'b0, 32'h0);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin errors++; $display("FAIL midreset_restart got req=%b addr=%h exp 1,%h", bus.imem_req, bus.imem_addr, RST_PC); end
        tick(1'b1, 1'b0, 32'h0);
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== RST_PC || bus.inst !== rom(RST_PC)) begin
            errors++; $display("FAIL midreset_first got v=%b pc=%h i=%h", bus.inst_valid, bus.inst_pc, bus.inst);
        end
    endtask

    task automatic test_random();
        logic        rdy, rv, prev_rv, prev_hold, exempt;
        logic [31:0] rpc, prev_inst, prev_pc;
        do_reset();
        exp_pc    = RST_PC;
        fetch_pc  = RST_PC;
        prev_rv   = 1'b0;
        prev_hold = 1'b0;
        prev_inst = '0;
        prev_pc   = '0;
        exempt    = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            rdy = ($urandom_range(0, 9) < 7);
            rv  = (i > 0) && ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       rpc = 32'hFFFF_FFF8 ^ ($urandom & 32'h3);
                1:       rpc = 32'($urandom_range(0, 15));
                default: rpc = $urandom;
            endcase
`ifdef FETCH_MISALIGN_CHECK_EN
            rpc = rpc & ~32'h3;
`endif
            tick(rdy, rv, rpc);
            if (!exempt && !prev_rv) begin
                checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL rnd_bubble i=%0d got=%b exp=1", i, bus.inst_valid); end
            end
            if (prev_rv) begin
                checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rnd_post_redirect_valid i=%0d got=%b exp=0", i, bus.inst_valid); end
            end
            if (prev_hold) begin
                checks++; if (bus.inst !== prev_inst || bus.inst_pc !== prev_pc) begin
                    errors++; $display("FAIL rnd_stable i=%0d got i=%h pc=%h exp i=%h pc=%h", i, bus.inst, bus.inst_pc, prev_inst, prev_pc);
                end
            end
            if (rv) begin
                checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rnd_redirect_req i=%0d got=%b exp=0", i, bus.imem_req); end
            end
            if (bus.imem_req === 1'b1) begin
                checks++; if (bus.imem_addr !== fetch_pc) begin errors++; $display("FAIL rnd_addr i=%0d got=%h exp=%h", i, bus.imem_addr, fetch_pc); end
                fetch_pc = fetch_pc + 32'd4;
            end
            if (bus.inst_valid === 1'b1 && rdy) begin
                checks++; if (bus.inst_pc !== exp_pc || bus.inst !== rom(exp_pc)) begin
                    errors++; $display("FAIL rnd_deliver i=%0d got pc=%h i=%h exp pc=%h i=%h", i, bus.inst_pc, bus.inst, exp_pc, rom(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (rv) begin
                exp_pc   = rpc & ~32'h3;
                fetch_pc = rpc & ~32'h3;
            end
            checks++; if (fetch_pc - exp_pc > 32'(4 * DEPTH)) begin errors++; $display("FAIL rnd_buffered i=%0d got=%0d exp<=%0d", i, (fetch_pc - exp_pc) / 4, DEPTH); end
            prev_hold = (bus.inst_valid === 1'b1) && !rdy && !rv;
            prev_inst = bus.inst;
            prev_pc   = bus.inst_pc;
            prev_rv   = rv;
            exempt    = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_misalign();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-issue RV32I core; sits directly upstream of decode/execute, which performs register writes such as the result of `or`. Holds the PC, issues word reads to the synchronous instruction ROM, and buffers returned instructions in a 2-entry FIFO. Hands instructions to decode over a valid/ready handshake and restarts cleanly on a control-flow redirect.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `BUF_DEPTH`, 2, instruction FIFO depth; must be at least 2 for full throughput.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `imem_req` output 1: ROM read request this cycle.
- `imem_addr` output 32: byte address of the read, always word-aligned.
- `imem_rdata` input 32: ROM data, valid exactly 1 cycle after `imem_req`.
- `redirect_valid` input 1: branch/jump taken; restart fetch.
- `redirect_pc` input 32: new fetch target.
- `inst_valid` output 1: FIFO head valid.
- `inst_ready` input 1: decode accepts head.
- `inst` output 32: instruction at FIFO head.
- `inst_pc` output 32: PC of `inst`.
- `fetch_fault` output 1: misaligned redirect target (see Configuration).

## Operation
- States: RESET, RUN, FAULT. RESET is held while `reset`=1 and for the first cycle after it falls. RESET goes to RUN. RUN goes to FAULT on a misaligned redirect. FAULT goes to RUN on an aligned redirect.
- In RUN, `imem_req`=1 when `count + inflight - pop < BUF_DEPTH`, where `pop` = `inst_valid & inst_ready`.
- On each request, `imem_addr`=pc and pc advances by 4 (32-bit wrap, 0xFFFF_FFFC becomes 0x0000_0000).
- One response is in flight at most per request. A response is pushed into the FIFO together with its request address.
- A handshake completes when `inst_valid & inst_ready`; the head is popped. `inst` and `inst_pc` must stay stable while `inst_valid`=1 and `inst_ready`=0.
- Redirect: the FIFO is cleared, any in-flight response is marked drop and discarded, and pc is set to `redirect_pc`. No request is issued in the redirect cycle.
- Simultaneous pop and redirect: redirect wins. The popped instruction counts as delivered; the rest are flushed.
- Reset has priority over redirect and over the handshake.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `inst_valid`=0, `inst`=0, `inst_pc`=`RESET_PC`, `fetch_fault`=0, FIFO empty, no response in flight.
- With `reset` falling before edge 0:
  - first `imem_req` in cycle 1, address `RESET_PC`;
  - first `inst_valid` in cycle 2.
- Steady state with `inst_ready` held at 1: one instruction per cycle, no bubbles.
- Redirect sampled in cycle N:
  - `inst_valid`=0 in N+1, with `imem_req`=1 at `redirect_pc`;
  - first new instruction valid in N+2.
- Backpressure: with `inst_ready`=0 the FIFO fills to `BUF_DEPTH` and `imem_req` drops. Requests resume in the cycle `inst_ready` returns.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - a redirect with `redirect_pc[1:0]`≠0 enters FAULT;
  - `fetch_fault`=1 from the next cycle;
  - no requests are issued and `inst_valid` stays 0;
  - the fault persists until an aligned redirect or reset.
- Undefined: `redirect_pc[1:0]` is forced to 0, `fetch_fault` is tied to 0, and FAULT is unreachable.

## Structure
- Shared core defines header holds `RESET_PC` default, the state encodings, and the instruction NOP constant 32'h0000_0013 used as the `inst` value after flush.
- One sub-module, `fetch_fifo`, is used:
  - parameterised by depth and width (64 bits: instruction and PC);
  - synchronous clear;
  - exposes `count`;
  - supports push and pop in the same cycle when full.

## Test plan
- Reset release with ROM holding an ADDI/ORI/OR sequence at 0x0, `inst_ready`=1 -> `imem_addr` 0x0, 0x4, 0x8 in cycles 1–3; `inst_pc` 0x0, 0x4, 0x8 in cycles 2–4; no bubbles.
- Hold `inst_ready`=0 from cycle 3 for 5 cycles -> at most 2 instructions buffered, `imem_req`=0 while full; on release, sequence continues with no loss or duplicates.
- `redirect_valid`=1 with `redirect_pc`=0x40 while FIFO has 2 entries and 1 in flight -> next valid `inst_pc`=0x40 exactly 2 cycles later; old instructions never appear.
- Redirect coincident with a handshake of PC 0x8 -> 0x8 delivered once; next `inst_pc`=redirect target.
- With the macro defined, `redirect_pc`=0x42 -> `fetch_fault`=1 next cycle and no requests; then redirect to 0x44 -> fault clears and fetch resumes at 0x44. With the macro undefined, the same target fetches 0x40.
- `reset` asserted mid-stream with FIFO full -> next cycle all outputs at reset values; restart at `RESET_PC`.
